// File: rtl/image_mem_loader.sv
// Byte-stream loader for the frame RAM write port.
// Header (width/height) then row-major pixels from BASE_ADDRESS.
module image_mem_loader #(
  parameter int                ADDR_W       = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = 'h10,
  parameter int                MAX_PIXELS   = 262128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pixel_count
);

  typedef enum logic [3:0] {
    IDLE, HDR_W_HI, HDR_W_LO, HDR_H_HI, HDR_H_LO,
    CHECK, PIXELS, DONE, ERROR
  } state_e;

  localparam logic [31:0] MaxPix = 32'(MAX_PIXELS);

  state_e            state_q, state_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] pcnt_q, pcnt_d;

  logic        accept;
  logic [31:0] total;
  logic [31:0] pcnt_nxt;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      HDR_W_HI, HDR_W_LO,
      HDR_H_HI, HDR_H_LO,
      PIXELS:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign total    = 32'(width_q) * 32'(height_q);
  assign pcnt_nxt = 32'(pcnt_q) + 32'd1;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    pcnt_d   = pcnt_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = HDR_W_HI;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          pcnt_d  = '0;
        end
      end
      HDR_W_HI: if (accept) begin
        wren_d        = 1'b1;
        waddr_d       = ADDR_W'(0);
        wdata_d       = in_data;
        width_d[15:8] = in_data;
        state_d       = HDR_W_LO;
      end
      HDR_W_LO: if (accept) begin
        wren_d       = 1'b1;
        waddr_d      = ADDR_W'(1);
        wdata_d      = in_data;
        width_d[7:0] = in_data;
        state_d      = HDR_H_HI;
      end
      HDR_H_HI: if (accept) begin
        wren_d         = 1'b1;
        waddr_d        = ADDR_W'(4);
        wdata_d        = in_data;
        height_d[15:8] = in_data;
        state_d        = HDR_H_LO;
      end
      HDR_H_LO: if (accept) begin
        wren_d        = 1'b1;
        waddr_d       = ADDR_W'(5);
        wdata_d       = in_data;
        height_d[7:0] = in_data;
        state_d       = CHECK;
      end
      CHECK: begin
        if (width_q == '0 || height_q == '0 || total > MaxPix) begin
          state_d = ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          state_d = PIXELS;
        end
      end
      PIXELS: if (accept) begin
        wren_d  = 1'b1;
        waddr_d = BASE_ADDRESS + pcnt_q;
        wdata_d = in_data;
        pcnt_d  = pcnt_q + ADDR_W'(1);
        // Last pixel: finish on the accepting edge
        if (pcnt_nxt == total) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign wren        = wren_q;
  assign wraddress   = waddr_q;
  assign data        = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pixel_count = pcnt_q;

endmodule

// File: tb/tb_image_mem_loader.sv
// Directed bench for image_mem_loader.
// Logs RAM writes and compares them against hand-built tables.
module tb_image_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] wraddress;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;
  logic        error;
  logic [17:0] pixel_count;

  image_mem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wraddress(wraddress),
    .data(data), .wren(wren), .busy(busy),
    .done(done), .error(error),
    .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int lat_err = 0;
  logic acc_prev = 1'b0;
  logic [25:0] wlog[$];

  logic [25:0] exp22[8] = '{
    {18'h0, 8'h00}, {18'h1, 8'h02},
    {18'h4, 8'h00}, {18'h5, 8'h02},
    {18'h10, 8'hAA}, {18'h11, 8'hBB},
    {18'h12, 8'hCC}, {18'h13, 8'hDD}
  };
  logic [7:0] s22[8] = '{
    8'h00, 8'h02, 8'h00, 8'h02,
    8'hAA, 8'hBB, 8'hCC, 8'hDD
  };

  // Write monitor: each wren must follow an accept by one cycle
  always @(negedge clk) begin
    if (rst) begin
      acc_prev = 1'b0;
    end else begin
      if (wren !== acc_prev) lat_err++;
      if (wren === 1'b1) wlog.push_back({wraddress, data});
      acc_prev = in_valid && in_ready;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    idle(1);
    in_valid = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int n);
    chk({tag, "_n"}, 32'(wlog.size()), 32'(n));
    for (int i = 0; i < n && i < wlog.size(); i++)
      chk(tag, 32'(wlog[i]), 32'(exp22[i]));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    idle(2);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", 32'(wraddress), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_pcnt", 32'(pixel_count), 0);
    rst = 1'b0;
    idle(2);

    // 2x2 streamed back to back
    pulse_start();
    chk("s1_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) send(s22[i]);
    idle(2);
    chk_log("s1_wr", 8);
    chk("s1_done", 32'(done), 1);
    chk("s1_busy0", 32'(busy), 0);
    chk("s1_pcnt", 32'(pixel_count), 4);
    chk("s1_lat", 32'(lat_err), 0);

    // zero width
    wlog.delete();
    pulse_start();
    send(8'h00); send(8'h00);
    send(8'h00); send(8'h05);
    idle(2);
    chk("s2_err", 32'(error), 1);
    chk("s2_done", 32'(done), 0);
    chk("s2_rdy", 32'(in_ready), 0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    idle(4);
    in_valid = 1'b0;
    idle(1);
    chk("s2_nwr", 32'(wlog.size()), 4);

    // oversize then a valid 1x1
    wlog.delete();
    pulse_start();
    send(8'h02); send(8'h00);
    send(8'h02); send(8'h00);
    idle(2);
    chk("s3_err", 32'(error), 1);
    chk("s3_nwr", 32'(wlog.size()), 4);
    wlog.delete();
    pulse_start();
    chk("s3_errclr", 32'(error), 0);
    send(8'h00); send(8'h01);
    send(8'h00); send(8'h01);
    send(8'h7F);
    idle(2);
    chk("s3_nwr2", 32'(wlog.size()), 5);
    if (wlog.size() == 5)
      chk("s3_pix", 32'(wlog[4]), 32'({18'h10, 8'h7F}));
    chk("s3_done", 32'(done), 1);
    chk("s3_pcnt", 32'(pixel_count), 1);

    // gaps between bytes
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(s22[i]);
      idle(1);
    end
    idle(2);
    chk_log("s4_wr", 8);
    chk("s4_done", 32'(done), 1);
    chk("s4_lat", 32'(lat_err), 0);

    // reset after third pixel accept
    wlog.delete();
    pulse_start();
    send(8'h00); send(8'h04);
    send(8'h00); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03);
    rst = 1'b1;
    #1;
    chk("s5_wren", 32'(wren), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_addr", 32'(wraddress), 0);
    chk("s5_pcnt", 32'(pixel_count), 0);
    chk("s5_rdy", 32'(in_ready), 0);
    idle(2);
    rst = 1'b0;
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    chk("s5_idle", 32'(in_ready), 0);
    chk("s5_nwr", 32'(wlog.size()), 6);

    // start during PIXELS is ignored
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send(s22[i]);
    pulse_start();
    chk("s6_busy", 32'(busy), 1);
    chk("s6_pmid", 32'(pixel_count), 2);
    send(s22[6]); send(s22[7]);
    idle(2);
    chk_log("s6_wr", 8);
    chk("s6_done", 32'(done), 1);
    chk("s6_pcnt", 32'(pixel_count), 4);
    chk("s6_lat", 32'(lat_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
